// File: rtl/udm_seq_16x16.sv
// Sequential 16x16 unsigned multiplier built from one shared 8x8 multiplier stepped over four partial products.
// Optional macro UDM_SEQ_ZERO_SKIP_EN: a zero operand skips the MUL steps and completes one edge after acceptance.

module udm_8x8 (
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] p
);
    assign p = x * y;
endmodule

module udm_seq_16x16 #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z,
    output logic               busy
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready is high only in IDLE; out_valid/z are held in DONE until out_ready is seen.

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t             state;
    logic [1:0]         step;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2*WIDTH-1:0] acc;
    logic [7:0]         mul_x;
    logic [7:0]         mul_y;
    logic [15:0]        pp;
    logic [2*WIDTH-1:0] pp_shifted;

    // step0 AL*BL, step1 AH*BL, step2 AL*BH, step3 AH*BH
    always_comb begin
        mul_x = a_q[7:0];
        mul_y = b_q[7:0];
        case (step)
            2'd1: mul_x = a_q[15:8];
            2'd2: mul_y = b_q[15:8];
            2'd3: begin
                mul_x = a_q[15:8];
                mul_y = b_q[15:8];
            end
            default: ;
        endcase
    end

    udm_8x8 u_mul (
        .x (mul_x),
        .y (mul_y),
        .p (pp)
    );

    always_comb begin
        pp_shifted = {16'd0, pp};
        case (step)
            2'd1, 2'd2: pp_shifted = {8'd0, pp, 8'd0};
            2'd3:       pp_shifted = {pp, 16'd0};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step      <= 2'd0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q  <= a;
                        b_q  <= b;
                        acc  <= '0;
                        step <= 2'd0;
`ifdef UDM_SEQ_ZERO_SKIP_EN
                        if (a == '0 || b == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= MUL;
                        end
`else
                        state <= MUL;
`endif
                    end
                end
                MUL: begin
                    acc  <= acc + pp_shifted;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign z        = acc;

endmodule

// File: doc/udm_seq_16x16.md
UDM_SEQ_16X16 -- requirements
Module: udm_seq_16x16

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; only 16 is legal, matching the shared UDM_8x8 half-width multiplier.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand pair a/b valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port a  input  WIDTH  unsigned multiplicand.
REQ-007 SHALL have port b  input  WIDTH  unsigned multiplier.
REQ-008 SHALL have port out_valid  output  1  product z valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts z.
REQ-010 SHALL have port z  output  2*WIDTH  unsigned product a*b.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL compute a*b by time-multiplexing exactly one UDM_8x8 instance over four partial products, with no other multiplier.
REQ-013 SHALL use a three-state FSM: IDLE, MUL, DONE.
REQ-014 SHALL drive in_ready high only in IDLE.
REQ-015 SHALL accept on a rising edge with in_valid=1 and in_ready=1: latch a and b, clear the 32-bit accumulator, set step=0, and go to MUL.
REQ-016 SHALL in MUL add one partial product per cycle in this order: step0 AL*BL<<0, step1 AH*BL<<8, step2 AL*BH<<8, step3 AH*BH<<16. AL/AH are a[7:0]/a[15:8]; BL/BH are b[7:0]/b[15:8].
REQ-017 SHALL do all accumulation modulo 2^32; the true product never exceeds 32 bits, so no overflow occurs.
REQ-018 SHALL move from MUL to DONE on the edge that adds step3, setting out_valid=1. out_valid is therefore first high 4 edges after the accepting edge.
REQ-019 SHALL drive z from the accumulator and hold z and out_valid stable in DONE while out_ready=0 (backpressure of unlimited length).
REQ-020 SHALL go from DONE to IDLE on the edge where out_ready=1, clearing out_valid. A new operand can be accepted no earlier than the following edge.
REQ-021 SHALL ignore in_valid, a and b outside IDLE, and ignore out_ready outside DONE.
REQ-022 SHALL use only the latched operands once MUL begins; changes on a or b after acceptance do not affect z.

Reset
REQ-023 SHALL on rst_n=0, immediately and independently of clk: set state=IDLE, step=0, accumulator=0, latched operands=0, z=0, out_valid=0, busy=0, in_ready=1.
REQ-024 SHALL abandon any in-flight operation on reset, including mid-MUL and in DONE, and produce no out_valid for it after rst_n deasserts.
REQ-025 SHALL accept a new operand pair on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL support macro UDM_SEQ_ZERO_SKIP_EN. When defined, an accepted pair with a==0 or b==0 goes directly from IDLE to DONE with z=0, so out_valid is high 1 edge after acceptance. When undefined, every pair takes the full 4-step MUL sequence, with identical z.

Verification
REQ-027 SHALL cover: a=0xFFFF, b=0xFFFF, out_ready=1 -> z=0xFFFE0001, out_valid first high 4 edges after acceptance, in_ready low for the 4 MUL cycles plus the DONE cycle.
REQ-028 SHALL cover: a=0x1234, b=0x5678, out_ready held 0 for 3 cycles after out_valid -> z=0x06260060 stable, in_ready=0 throughout, return to IDLE on the edge with out_ready=1.
REQ-029 SHALL cover: a=0x1234, b=0x5678 accepted, a/b changed to 0xFFFF during MUL -> z still 0x06260060.
REQ-030 SHALL cover: rst_n pulsed low during MUL step2 -> out_valid=0, z=0, in_ready=1 immediately. A following pair a=0x0002, b=0x0003 gives z=0x00000006.
REQ-031 SHALL cover: a=0x0000, b=0x1234 -> z=0. out_valid high 1 edge after acceptance with UDM_SEQ_ZERO_SKIP_EN defined, and 4 edges after acceptance without it.
REQ-032 SHALL cover: back-to-back pairs with in_valid held high and out_ready=1 -> pairs accepted every 6 cycles with the 4-step sequence, each z equal to its a*b.
